// File: rtl/perf_cnt_pkg.sv
// Shared definitions for the performance counter and the timer compare unit.
// The direction encoding and the next-count step function live here so both
// blocks agree on wrap/saturate behaviour.
package perf_cnt_pkg;

  // Widest counter the step function supports.
  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Returns {ovf, next}. Only the low 'width' bits of cnt are significant.
  // An ovf is reported whenever a step hits a bound, whether it wraps or holds.
  function automatic logic [MAX_W:0] next_count(input logic [MAX_W-1:0] cnt,
                                                input dir_e dir,
                                                input logic sat,
                                                input int unsigned width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] nxt;
    logic             ovf;
    mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
    ovf  = 1'b0;
    if (dir == DIR_UP) begin
      if ((cnt & mask) == mask) begin
        ovf = 1'b1;
        nxt = sat ? mask : '0;
      end else begin
        nxt = cnt + 64'd1;
      end
    end else begin
      if ((cnt & mask) == '0) begin
        ovf = 1'b1;
        nxt = sat ? '0 : mask;
      end else begin
        nxt = cnt - 64'd1;
      end
    end
    return {ovf, nxt & mask};
  endfunction

endpackage

// File: rtl/perf_cnt_prescaler.sv
// Prescaler for perf_counter: emits tick on every (div + 1)-th enabled cycle.
// The count holds while en is low, so disabled cycles stretch the period.
module perf_cnt_prescaler
  import perf_cnt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] pre;

  // Terminal count reached; only acted on when en is high.
  assign tick = (pre == div);

  // Divider state: cleared by reset and load, advances only on enabled cycles.
  always_ff @(posedge clk) begin
    if (reset || load) pre <= '0;
    else if (en) begin
      if (tick) pre <= '0;
      else      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter.sv
// Parametrised up/down event counter with load, wrap/saturate, compare match
// and sticky overflow flag. Define PERF_CNT_PRESCALE_EN to add the
// prescale_div port and an enable prescaler in front of the step.
module perf_counter
  import perf_cnt_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SATURATE   = 0,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      cmp_val,
  input  logic                  clr_flag,
`ifdef PERF_CNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  cmp_match,
  output logic                  ovf_pulse,
  output logic                  ovf_flag
);

  logic          tick;
  logic          step;
  logic          ovf;
  logic [MAX_W:0] nc;

`ifdef PERF_CNT_PRESCALE_EN
  perf_cnt_prescaler #(.W(PRESCALE_W)) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .load  (load),
    .div   (prescale_div),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Load takes priority over a step in the same cycle.
  assign step = en & tick & ~load;
  assign nc   = next_count(MAX_W'(count), dir_e'(up), SATURATE != 0, WIDTH);
  assign ovf  = nc[MAX_W];

  generate
    if (WIDTH < MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^nc[MAX_W-1:WIDTH];
    end
  endgenerate

  assign cmp_match = (count == cmp_val);

  // Count register: reset > load > step.
  always_ff @(posedge clk) begin
    if (reset)     count <= '0;
    else if (load) count <= load_val;
    else if (step) count <= nc[WIDTH-1:0];
  end

  // Overflow pulse tracks the step edge; sticky flag set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_pulse <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      ovf_pulse <= step & ovf;
      if (step && ovf) ovf_flag <= 1'b1;
      else if (clr_flag) ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perf_counter.sv
// Directed bench for perf_counter: an 8-bit wrapping instance, an 8-bit
// saturating instance and a 16-bit wrapping instance share one stimulus.
module tb_perf_counter;

  logic        clk = 1'b0;
  logic        reset, en, up, load, clr_flag;
  logic [15:0] load_val, cmp_val;
`ifdef PERF_CNT_PRESCALE_EN
  logic [7:0]  prescale_div = 8'd3;
`endif

  logic [7:0]  count_w, count_s;
  logic [15:0] count_l;
  logic        cm_w, cm_s, cm_l;
  logic        op_w, op_s, op_l;
  logic        of_w, of_s, of_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_counter #(.WIDTH(8), .SATURATE(0), .PRESCALE_W(8)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[7:0]), .cmp_val(cmp_val[7:0]), .clr_flag(clr_flag),
`ifdef PERF_CNT_PRESCALE_EN
    .prescale_div(prescale_div),
`endif
    .count(count_w), .cmp_match(cm_w), .ovf_pulse(op_w), .ovf_flag(of_w));

  perf_counter #(.WIDTH(8), .SATURATE(1), .PRESCALE_W(8)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[7:0]), .cmp_val(cmp_val[7:0]), .clr_flag(clr_flag),
`ifdef PERF_CNT_PRESCALE_EN
    .prescale_div(prescale_div),
`endif
    .count(count_s), .cmp_match(cm_s), .ovf_pulse(op_s), .ovf_flag(of_s));

  perf_counter #(.WIDTH(16), .SATURATE(0), .PRESCALE_W(8)) dut_l (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .clr_flag(clr_flag),
`ifdef PERF_CNT_PRESCALE_EN
    .prescale_div(prescale_div),
`endif
    .count(count_l), .cmp_match(cm_l), .ovf_pulse(op_l), .ovf_flag(of_l));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; clr_flag = 1'b0;
    load_val = '0; cmp_val = 16'hffff;
    cyc(); cyc();
    checks++;
    if (count_w !== 8'h00 || count_s !== 8'h00 || count_l !== 16'h0000) begin
      failures++;
      $display("FAIL reset_init counts w=%h s=%h l=%h want 0", count_w, count_s, count_l);
    end
    checks++;
    if ({op_w, op_s, op_l, of_w, of_s, of_l} !== 6'b0) begin
      failures++;
      $display("FAIL reset_init flags=%b want 000000", {op_w, op_s, op_l, of_w, of_s, of_l});
    end
    reset = 1'b0;
    do_load(16'h1234);
    checks++;
    if (count_l !== 16'h1234) begin
      failures++; $display("FAIL load_1234 got %h want 1234", count_l);
    end
    en = 1'b1; up = 1'b1;
    cyc();
    checks++;
    if (count_l !== 16'h1235) begin
      failures++; $display("FAIL count_1235 got %h want 1235", count_l);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0; en = 1'b0;
    checks++;
    if (count_l !== 16'h0 || count_w !== 8'h0 || of_l !== 1'b0 || op_l !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got l=%h w=%h pulse=%b flag=%b want 0", count_l, count_w, op_l, of_l);
    end
  endtask

  task automatic test_wrap_up();
    logic [7:0] ew [3] = '{8'hff, 8'h00, 8'h01};
    logic [7:0] es [3] = '{8'hff, 8'hff, 8'hff};
    logic       pw [3] = '{1'b0, 1'b1, 1'b0};
    logic       ps [3] = '{1'b0, 1'b1, 1'b1};
    do_load(16'h00fe);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (count_w !== ew[i] || op_w !== pw[i]) begin
        failures++;
        $display("FAIL wrap_up[%0d] got cnt=%h pulse=%b want cnt=%h pulse=%b", i, count_w, op_w, ew[i], pw[i]);
      end
      checks++;
      if (count_s !== es[i] || op_s !== ps[i]) begin
        failures++;
        $display("FAIL sat_up[%0d] got cnt=%h pulse=%b want cnt=%h pulse=%b", i, count_s, op_s, es[i], ps[i]);
      end
    end
    checks++;
    if (of_w !== 1'b1 || of_s !== 1'b1) begin
      failures++; $display("FAIL wrap_flag got w=%b s=%b want 1 1", of_w, of_s);
    end
    // Disabled cycle: count holds, pulse drops, flag holds.
    en = 1'b0;
    cyc();
    checks++;
    if (count_w !== 8'h01 || op_s !== 1'b0 || count_s !== 8'hff || of_w !== 1'b1) begin
      failures++;
      $display("FAIL hold_en0 got w=%h s=%h ps=%b fw=%b want 01 ff 0 1", count_w, count_s, op_s, of_w);
    end
    clr_flag = 1'b1;
    cyc();
    clr_flag = 1'b0;
    checks++;
    if (of_w !== 1'b0 || of_s !== 1'b0) begin
      failures++; $display("FAIL clr_flag got w=%b s=%b want 0 0", of_w, of_s);
    end
  endtask

  task automatic test_sat_down();
    logic [7:0] ew [4] = '{8'h00, 8'hff, 8'hfe, 8'hfd};
    logic       pw [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int         npulse = 0;
    do_load(16'h0001);
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (op_s === 1'b1) npulse++;
      checks++;
      if (count_s !== 8'h00 || op_s !== (i > 0)) begin
        failures++;
        $display("FAIL sat_down[%0d] got cnt=%h pulse=%b want cnt=00 pulse=%b", i, count_s, op_s, i > 0);
      end
      checks++;
      if (count_w !== ew[i] || op_w !== pw[i]) begin
        failures++;
        $display("FAIL wrap_down[%0d] got cnt=%h pulse=%b want cnt=%h pulse=%b", i, count_w, op_w, ew[i], pw[i]);
      end
    end
    en = 1'b0;
    checks++;
    if (npulse != 3 || of_s !== 1'b1) begin
      failures++; $display("FAIL sat_pulses got %0d flag=%b want 3 1", npulse, of_s);
    end
  endtask

  task automatic test_load_priority();
    clr_flag = 1'b1;
    do_load(16'h00ff);
    clr_flag = 1'b0;
    load = 1'b1; load_val = 16'h0055; en = 1'b1; up = 1'b1;
    cyc();
    load = 1'b0; en = 1'b0;
    checks++;
    if (count_w !== 8'h55 || op_w !== 1'b0 || of_w !== 1'b0) begin
      failures++;
      $display("FAIL load_vs_step got cnt=%h pulse=%b flag=%b want 55 0 0", count_w, op_w, of_w);
    end
    do_load(16'h00ff);
    en = 1'b1; up = 1'b1; clr_flag = 1'b1;
    cyc();
    en = 1'b0; clr_flag = 1'b0;
    checks++;
    if (count_w !== 8'h00 || op_w !== 1'b1 || of_w !== 1'b1) begin
      failures++;
      $display("FAIL set_beats_clr got cnt=%h pulse=%b flag=%b want 00 1 1", count_w, op_w, of_w);
    end
  endtask

  task automatic test_compare();
    logic [7:0] ec [4] = '{8'h0f, 8'h10, 8'h11, 8'h12};
    logic       em [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    cmp_val = 16'h0010;
    do_load(16'h000e);
    checks++;
    if (cm_w !== 1'b0 || count_w !== 8'h0e) begin
      failures++; $display("FAIL cmp_0e got cnt=%h match=%b want 0e 0", count_w, cm_w);
    end
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (count_w !== ec[i] || cm_w !== em[i] || cm_l !== em[i]) begin
        failures++;
        $display("FAIL cmp[%0d] got cnt=%h match=%b/%b want cnt=%h match=%b", i, count_w, cm_w, cm_l, ec[i], em[i]);
      end
    end
    en = 1'b0; cmp_val = 16'hffff;
  endtask

  task automatic test_prescale();
`ifdef PERF_CNT_PRESCALE_EN
    logic [7:0] e12 = 8'd3, e3 = 8'd3, e4 = 8'd4;
`else
    logic [7:0] e12 = 8'd12, e3 = 8'd15, e4 = 8'd16;
`endif
    do_load(16'h0000);
    en = 1'b1; up = 1'b1;
    repeat (12) cyc();
    checks++;
    if (count_w !== e12) begin
      failures++; $display("FAIL presc_12 got %0d want %0d", count_w, e12);
    end
    repeat (2) cyc();
    en = 1'b0;
    repeat (2) cyc();
    en = 1'b1;
    cyc();
    checks++;
    if (count_w !== e3) begin
      failures++; $display("FAIL presc_gap got %0d want %0d", count_w, e3);
    end
    cyc();
    en = 1'b0;
    checks++;
    if (count_w !== e4) begin
      failures++; $display("FAIL presc_ext got %0d want %0d", count_w, e4);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_priority();
    test_compare();
    test_prescale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
